// File: rtl/instr_encoder_loader_if.sv
// Load-request and instruction-field handshake plus the instruction-memory write port
// for instr_encoder_loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic                 start;
    logic [ADDR_W:0]      count;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_cls;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [2:0]           in_funct3;
    logic                 in_funct7b5;
    logic signed [31:0]   in_imm;
    logic                 imem_we;
    logic [ADDR_W-1:0]    imem_addr;
    logic [31:0]          imem_wdata;
    logic                 busy;
    logic                 done;
    logic                 err_illegal;

    modport master (
        output start, count, in_valid, in_cls, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7b5, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal
    );

    modport slave (
        input  start, count, in_valid, in_cls, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7b5, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instruction fields into 32-bit words and writes a counted block of them
// into instruction memory starting at BASE_ADDR; illegal classes are dropped and flagged.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_encoder_loader_if.slave  bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                legal;
    logic [31:0]         enc_word;

    function automatic logic [31:0] encode(
        input logic [3:0]         cls,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         f3,
        input logic               f7b5,
        input logic signed [31:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (cls)
            4'd0: w = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
            4'd1: begin
                // Shifts carry shamt in the immediate slot and funct7 above it.
                if (f3 == 3'b001 || f3 == 3'b101)
                    w = {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, OP_I};
                else
                    w = {imm[11:0], rs1, f3, rd, OP_I};
            end
            4'd2: w = {imm[11:0], rs1, f3, rd, OP_LOAD};
            4'd3: w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            4'd4: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            4'd5: w = {imm[31:12], rd, OP_LUI};
            4'd6: w = {imm[31:12], rd, OP_AUIPC};
            4'd7: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            4'd8: w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            default: w = '0;
        endcase
        return w;
    endfunction

    assign legal    = (bus.in_cls <= 4'd8);
    assign enc_word = encode(bus.in_cls, bus.in_rd, bus.in_rs1, bus.in_rs2,
                             bus.in_funct3, bus.in_funct7b5, bus.in_imm);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ptr_d   = ADDR_W'(BASE_ADDR);
                    rem_d   = bus.count;
                    err_d   = 1'b0;
                    state_d = (bus.count != '0) ? LOAD : DRAIN;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        rem_d   = rem_q - (ADDR_W+1)'(1);
                        if (rem_q == (ADDR_W+1)'(1))
                            state_d = DRAIN;
                    end
                end
            end
            DRAIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // The DRAIN cycle is the one carrying the final write, so done follows the state.
    assign bus.in_ready    = (state_q == LOAD);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DRAIN);
    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = addr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: known-encoding table, timing sequences, wrap, reset
// mid-load, and randomized loads against a field-arithmetic reference model.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_loader_if #(.ADDR_W(8)) a ();
    instr_encoder_loader_if #(.ADDR_W(2)) b ();

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(a));
    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b));

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
    } beat_t;

    typedef struct {
        beat_t       b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    wr_t   got_q[$];
    int    done_cnt = 0;
    vec_t  vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input int cls, input int rd, input int rs1, input int rs2,
                                 input int f3, input int f7b5, input int imm);
        beat_t r;
        r.cls = 4'(cls); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
        r.f3 = 3'(f3); r.f7b5 = 1'(f7b5); r.imm = 32'(imm);
        return r;
    endfunction

    // Reference encoder: each field is masked out of the immediate and shifted into place.
    function automatic logic [31:0] ref_encode(input beat_t bt);
        int unsigned rd, rs1, rs2, f3, f7, im, w;
        rd = bt.rd; rs1 = bt.rs1; rs2 = bt.rs2; f3 = bt.f3; f7 = bt.f7b5; im = bt.imm;
        w = 0;
        case (bt.cls)
            0: w = 'h33 | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 30;
            1: if (f3 == 1 || f3 == 5)
                   w = 'h13 | rd << 7 | f3 << 12 | rs1 << 15 | (im & 31) << 20 | f7 << 30;
               else
                   w = 'h13 | rd << 7 | f3 << 12 | rs1 << 15 | (im & 4095) << 20;
            2: w = 'h03 | rd << 7 | f3 << 12 | rs1 << 15 | (im & 4095) << 20;
            3: w = 'h23 | (im & 31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((im >> 5) & 127) << 25;
            4: w = 'h63 | ((im >> 11) & 1) << 7 | ((im >> 1) & 15) << 8 | f3 << 12 | rs1 << 15
                   | rs2 << 20 | ((im >> 5) & 63) << 25 | ((im >> 12) & 1) << 31;
            5: w = 'h37 | rd << 7 | (im & 32'hFFFFF000);
            6: w = 'h17 | rd << 7 | (im & 32'hFFFFF000);
            7: w = 'h6F | rd << 7 | ((im >> 12) & 255) << 12 | ((im >> 11) & 1) << 20
                   | ((im >> 1) & 1023) << 21 | ((im >> 20) & 1) << 31;
            8: w = 'h67 | rd << 7 | rs1 << 15 | (im & 4095) << 20;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic beat_t rand_beat(input bit legal);
        beat_t r;
        r.cls  = legal ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
        r.rd   = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
        r.f3   = 3'($urandom); r.f7b5 = 1'($urandom); r.imm = $urandom;
        return r;
    endfunction

    task automatic set_beat(input beat_t bt);
        a.in_cls = bt.cls; a.in_rd = bt.rd; a.in_rs1 = bt.rs1; a.in_rs2 = bt.rs2;
        a.in_funct3 = bt.f3; a.in_funct7b5 = bt.f7b5; a.in_imm = bt.imm;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a.imem_we) got_q.push_back('{a.imem_addr, a.imem_wdata});
            if (a.done) done_cnt++;
        end
    end

    // One complete load on dut0 (BASE_ADDR 0), checked against the reference model.
    task automatic do_load(input int cnt, input beat_t beats[$], input bit gaps);
        wr_t exp_q[$];
        bit  any_ill;
        int  k, w;
        k = 0; any_ill = 1'b0;
        foreach (beats[i]) begin
            if (beats[i].cls <= 8) begin
                exp_q.push_back('{8'(k), ref_encode(beats[i])});
                k++;
            end else begin
                any_ill = 1'b1;
            end
        end
        got_q.delete();
        done_cnt = 0;
        a.start = 1'b1; a.count = 9'(cnt);
        tick();
        a.start = 1'b0;
        foreach (beats[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                a.in_valid = 1'b0;
                tick();
            end
            set_beat(beats[i]);
            a.in_valid = 1'b1;
            tick();
        end
        a.in_valid = 1'b0;
        w = 0;
        while (a.busy && w < 20) begin
            tick();
            w++;
        end
        check("load_returns_idle", a.busy, 0);
        check("write_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("write_addr", got_q[i].addr, exp_q[i].addr);
            check("write_data", got_q[i].data, exp_q[i].data);
        end
        check("done_pulses", done_cnt, 1);
        check("err_illegal", a.err_illegal, any_ill);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        beat_t q[$];
        int    cnt;

        vecs[0]  = '{mk(1, 1, 0, 0, 0, 0, 10),          32'h00A00093};
        vecs[1]  = '{mk(0, 3, 1, 2, 0, 1, 0),           32'h402081B3};
        vecs[2]  = '{mk(3, 7, 2, 1, 2, 0, 8),           32'h00112423};
        vecs[3]  = '{mk(4, 0, 1, 2, 0, 0, 16),          32'h00208863};
        vecs[4]  = '{mk(7, 1, 0, 0, 0, 0, 8),           32'h008000EF};
        vecs[5]  = '{mk(5, 5, 3, 0, 0, 0, 'h12345ABC),  32'h123452B7};
        vecs[6]  = '{mk(2, 5, 2, 0, 2, 0, -4),          32'hFFC12283};
        vecs[7]  = '{mk(1, 1, 2, 0, 5, 1, 3),           32'h40315093};
        vecs[8]  = '{mk(8, 0, 1, 0, 7, 0, 0),           32'h00008067};
        vecs[9]  = '{mk(6, 3, 0, 0, 0, 0, 'h1000),      32'h00001197};
        vecs[10] = '{mk(4, 0, 0, 0, 0, 0, -2),          32'hFE000FE3};
        vecs[11] = '{mk(1, 1, 0, 0, 0, 1, 10),          32'h00A00093};
        vecs[12] = '{mk(7, 1, 0, 0, 0, 0, 9),           32'h008000EF};

        a.start = 0; a.count = '0; a.in_valid = 0; set_beat(mk(0, 0, 0, 0, 0, 0, 0));
        b.start = 0; b.count = '0; b.in_valid = 0; b.in_cls = '0; b.in_rd = '0;
        b.in_rs1 = '0; b.in_rs2 = '0; b.in_funct3 = '0; b.in_funct7b5 = 0; b.in_imm = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", a.imem_we, 0);
        check("rst_addr", a.imem_addr, 0);
        check("rst_wdata", a.imem_wdata, 0);
        check("rst_busy", a.busy, 0);
        check("rst_done", a.done, 0);
        check("rst_in_ready", a.in_ready, 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", a.busy, 0);

        // Known-encoding table, one word per load
        foreach (vecs[i]) begin
            q.delete();
            q.push_back(vecs[i].b);
            do_load(1, q, 1'b0);
            if (got_q.size() > 0) check($sformatf("vec%0d_word", i), got_q[0].data, vecs[i].exp);
        end

        // Back-to-back ADDI then SUB with cycle-exact timing
        a.start = 1; a.count = 9'd2;
        tick();
        a.start = 0;
        check("b2b_ready", a.in_ready, 1);
        set_beat(mk(1, 1, 0, 0, 0, 0, 10)); a.in_valid = 1;
        tick();
        check("b2b_we0", a.imem_we, 1);
        check("b2b_addr0", a.imem_addr, 0);
        check("b2b_data0", a.imem_wdata, 32'h00A00093);
        check("b2b_done0", a.done, 0);
        set_beat(mk(0, 3, 1, 2, 0, 1, 0));
        tick();
        a.in_valid = 0;
        check("b2b_we1", a.imem_we, 1);
        check("b2b_addr1", a.imem_addr, 1);
        check("b2b_data1", a.imem_wdata, 32'h402081B3);
        check("b2b_done1", a.done, 1);
        check("b2b_ready_drain", a.in_ready, 0);
        tick();
        check("b2b_busy_after", a.busy, 0);
        check("b2b_done_after", a.done, 0);
        check("b2b_we_after", a.imem_we, 0);
        check("b2b_data_hold", a.imem_wdata, 32'h402081B3);

        // Illegal beat dropped, sticky error until next start
        a.start = 1; a.count = 9'd1;
        tick();
        a.start = 0;
        set_beat(mk(12, 1, 1, 1, 0, 0, 0)); a.in_valid = 1;
        tick();
        check("ill_no_write", a.imem_we, 0);
        check("ill_err_set", a.err_illegal, 1);
        check("ill_still_busy", a.busy, 1);
        set_beat(mk(5, 5, 0, 0, 0, 0, 'h12345000));
        tick();
        a.in_valid = 0;
        check("ill_lui_data", a.imem_wdata, 32'h123452B7);
        check("ill_lui_addr", a.imem_addr, 0);
        check("ill_lui_done", a.done, 1);
        repeat (3) tick();
        check("ill_err_sticky", a.err_illegal, 1);
        a.start = 1; a.count = 9'd0;
        tick();
        a.start = 0;
        check("zero_err_cleared", a.err_illegal, 0);
        check("zero_done", a.done, 1);
        check("zero_no_write", a.imem_we, 0);
        tick();
        check("zero_idle", a.busy, 0);

        // Narrow pointer wrap on dut1 (ADDR_W=2, BASE_ADDR=3)
        b.start = 1; b.count = 3'd2;
        tick();
        b.start = 0;
        b.in_cls = 4'd1; b.in_rd = 5'd1; b.in_imm = 32'd10; b.in_valid = 1;
        tick();
        check("wrap_we0", b.imem_we, 1);
        check("wrap_addr0", b.imem_addr, 3);
        tick();
        b.in_valid = 0;
        check("wrap_we1", b.imem_we, 1);
        check("wrap_addr1", b.imem_addr, 0);
        check("wrap_done", b.done, 1);
        tick();
        b.start = 1; b.count = 3'd0;
        tick();
        b.start = 0;
        check("wrap_zero_done", b.done, 1);
        check("wrap_zero_no_we", b.imem_we, 0);
        tick();
        check("wrap_zero_done_end", b.done, 0);
        check("wrap_zero_idle", b.busy, 0);

        // Asynchronous reset mid-load with one instruction still outstanding
        a.start = 1; a.count = 9'd2;
        tick();
        a.start = 0;
        set_beat(mk(13, 0, 0, 0, 0, 0, 0)); a.in_valid = 1;
        tick();
        set_beat(mk(1, 1, 0, 0, 0, 0, 10));
        tick();
        a.in_valid = 0;
        check("mid_pre_we", a.imem_we, 1);
        check("mid_pre_err", a.err_illegal, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", a.imem_we, 0);
        check("mid_rst_addr", a.imem_addr, 0);
        check("mid_rst_wdata", a.imem_wdata, 0);
        check("mid_rst_busy", a.busy, 0);
        check("mid_rst_done", a.done, 0);
        check("mid_rst_err", a.err_illegal, 0);
        check("mid_rst_ready", a.in_ready, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", a.busy, 0);
        check("post_rst_ready", a.in_ready, 0);
        q.delete();
        q.push_back(mk(8, 2, 3, 0, 0, 0, -8));
        do_load(1, q, 1'b0);

        // Randomized loads with illegal beats and valid gaps
        for (int n = 0; n < 25; n++) begin
            cnt = $urandom_range(1, 6);
            q.delete();
            for (int j = 0; j < cnt; j++) begin
                if ($urandom_range(0, 4) == 0) q.push_back(rand_beat(1'b0));
                q.push_back(rand_beat(1'b1));
            end
            do_load(cnt, q, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
